pmpadrenc: RTL and testbench

Sequential PMP region encoder: the write-side counterpart of the PMP address decoder. It accepts a region request (byte base, byte size, permissions, lock, entry index) and chooses the cheapest legal addressing mode: NA4, NAPOT, or TOR (which consumes two entries). It then emits the pmpaddr/pmpcfg CSR writes over a valid/ready port into the PMP CSR file. It sits between the privileged-mode firmware-assist/debug path and the PMP CSR registers.

---
 rtl/pmpadrenc.sv | 227 ++++++++++++++++++++++
 tb/tb_pmpadrenc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmpadrenc.sv
// PMP region encoder: turns a {base, size, perm, lock, index} request into the
// cheapest legal pmpaddr/pmpcfg write sequence (NA4, NAPOT or two-entry TOR).
module pmpadrenc #(
  parameter  int unsigned PA_BITS     = 56,
  parameter  int unsigned PMP_ENTRIES = 16,
  localparam int unsigned IW          = $clog2(PMP_ENTRIES),
  localparam int unsigned AW          = PA_BITS - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic [PA_BITS-1:0] ReqBase,
  input  logic [PA_BITS-1:0] ReqSize,
  input  logic [IW-1:0]      ReqIndex,
  input  logic [2:0]         ReqPerm,
  input  logic               ReqLock,
  output logic               WrValid,
  input  logic               WrReady,
  output logic               WrIsCfg,
  output logic [IW-1:0]      WrIndex,
  output logic [AW-1:0]      WrAdr,
  output logic [7:0]         WrCfg,
  output logic               Done,
  output logic               Err,
  output logic [1:0]         ErrCode
);

  typedef enum logic [2:0] {
    IDLE, CLASSIFY, WADR0, WADR1, WCFG0, WCFG1
  } state_t;

  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  state_t state, state_n;

  logic [PA_BITS-1:0] base_q, size_q;
  logic [IW-1:0]      idx_q;
  logic [2:0]         perm_q;
  logic               lock_q;

  // Classification results carried into the write states
  logic [AW-1:0] top_adr_q, top_adr_n;
  logic [1:0]    mode_q, mode_n;
  logic          two_q, two_n;

  logic          rdy_n, wv_n, iscfg_n, done_n, err_n;
  logic [IW-1:0] widx_n;
  logic [AW-1:0] wadr_n;
  logic [7:0]    wcfg_n;
  logic [1:0]    code_n;

  logic               accept;
  logic [PA_BITS:0]   sum;
  logic               bad_align, ovf, is_na4, is_pow2, is_napot, is_tor;
  logic               tor_low_bad, two_entry;
  logic [1:0]         mode_c;
  logic [AW-1:0]      adr_c, napot_mask;

  assign accept = ReqValid && ReqReady;

  // Request capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      size_q <= '0;
      idx_q  <= '0;
      perm_q <= '0;
      lock_q <= 1'b0;
    end else if (accept) begin
      base_q <= ReqBase;
      size_q <= ReqSize;
      idx_q  <= ReqIndex;
      perm_q <= ReqPerm;
      lock_q <= ReqLock;
    end
  end

  // Region classification on the latched request
  assign sum         = {1'b0, base_q} + {1'b0, size_q};
  assign bad_align   = (size_q == '0) || (base_q[1:0] != 2'b00) || (size_q[1:0] != 2'b00);
  assign ovf         = sum[PA_BITS] && (sum[PA_BITS-1:0] != '0);
  assign is_na4      = (size_q == PA_BITS'(4));
  assign is_pow2     = ((size_q & (size_q - PA_BITS'(1))) == '0);
  assign is_napot    = is_pow2 && (size_q[PA_BITS-1:3] != '0) &&
                       ((base_q & (size_q - PA_BITS'(1))) == '0);
  assign is_tor      = !is_na4 && !is_napot;
  assign tor_low_bad = is_tor && (idx_q == '0) && (base_q != '0);
  assign two_entry   = is_tor && (idx_q != '0);
  assign napot_mask  = {1'b0, size_q[PA_BITS-1:3]} - AW'(1);

  always_comb begin
    mode_c = A_TOR;
    adr_c  = sum[PA_BITS-1:2];
    if (is_na4) begin
      mode_c = A_NA4;
      adr_c  = base_q[PA_BITS-1:2];
    end else if (is_napot) begin
      mode_c = A_NAPOT;
      adr_c  = base_q[PA_BITS-1:2] | napot_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ReqReady  <= 1'b1;
      WrValid   <= 1'b0;
      WrIsCfg   <= 1'b0;
      WrIndex   <= '0;
      WrAdr     <= '0;
      WrCfg     <= '0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      ErrCode   <= 2'b00;
      top_adr_q <= '0;
      mode_q    <= 2'b00;
      two_q     <= 1'b0;
    end else begin
      state     <= state_n;
      ReqReady  <= rdy_n;
      WrValid   <= wv_n;
      WrIsCfg   <= iscfg_n;
      WrIndex   <= widx_n;
      WrAdr     <= wadr_n;
      WrCfg     <= wcfg_n;
      Done      <= done_n;
      Err       <= err_n;
      ErrCode   <= code_n;
      top_adr_q <= top_adr_n;
      mode_q    <= mode_n;
      two_q     <= two_n;
    end
  end

  // Next state and next registered outputs; Wr* hold until a handshake
  always_comb begin
    state_n   = state;
    rdy_n     = ReqReady;
    wv_n      = WrValid;
    iscfg_n   = WrIsCfg;
    widx_n    = WrIndex;
    wadr_n    = WrAdr;
    wcfg_n    = WrCfg;
    done_n    = 1'b0;
    err_n     = 1'b0;
    code_n    = ErrCode;
    top_adr_n = top_adr_q;
    mode_n    = mode_q;
    two_n     = two_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = CLASSIFY;
          rdy_n   = 1'b0;
        end
      end
      CLASSIFY: begin
        if (bad_align || ovf || tor_low_bad) begin
          state_n = IDLE;
          rdy_n   = 1'b1;
          err_n   = 1'b1;
          code_n  = bad_align ? 2'b01 : (ovf ? 2'b10 : 2'b11);
        end else begin
          top_adr_n = adr_c;
          mode_n    = mode_c;
          two_n     = two_entry;
          wv_n      = 1'b1;
          iscfg_n   = 1'b0;
          if (two_entry) begin
            state_n = WADR0;
            widx_n  = idx_q - IW'(1);
            wadr_n  = base_q[PA_BITS-1:2];
          end else begin
            state_n = WADR1;
            widx_n  = idx_q;
            wadr_n  = adr_c;
          end
        end
      end
      WADR0: begin
        if (WrReady) begin
          state_n = WADR1;
          widx_n  = idx_q;
          wadr_n  = top_adr_q;
        end
      end
      WADR1: begin
        if (WrReady) begin
          iscfg_n = 1'b1;
          if (two_q) begin
            state_n = WCFG0;
            widx_n  = idx_q - IW'(1);
            wcfg_n  = {lock_q, 7'b000_0000};
          end else begin
            state_n = WCFG1;
            widx_n  = idx_q;
            wcfg_n  = {lock_q, 2'b00, mode_q, perm_q};
          end
        end
      end
      WCFG0: begin
        if (WrReady) begin
          state_n = WCFG1;
          widx_n  = idx_q;
          wcfg_n  = {lock_q, 2'b00, mode_q, perm_q};
        end
      end
      WCFG1: begin
        if (WrReady) begin
          state_n = IDLE;
          wv_n    = 1'b0;
          rdy_n   = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        rdy_n   = 1'b1;
        wv_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pmpadrenc.sv
// Directed table-driven bench for pmpadrenc plus backpressure and mid-sequence reset cases.
module tb_pmpadrenc;

  localparam int unsigned PA = 56;
  localparam int unsigned NE = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned AW = PA - 2;

  typedef struct packed {
    logic          cfg;
    logic [IW-1:0] idx;
    logic [AW-1:0] val;
  } wr_t;

  typedef struct packed {
    logic [PA-1:0] base;
    logic [PA-1:0] size;
    logic [IW-1:0] idx;
    logic [2:0]    perm;
    logic          lock;
    logic [2:0]    nwr;
    logic          err;
    logic [1:0]    code;
    logic [4:0]    end_cyc;
    wr_t [3:0]     w;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic [PA-1:0] ReqBase = '0;
  logic [PA-1:0] ReqSize = '0;
  logic [IW-1:0] ReqIndex = '0;
  logic [2:0]    ReqPerm = '0;
  logic          ReqLock = 1'b0;
  logic          WrValid;
  logic          WrReady = 1'b1;
  logic          WrIsCfg;
  logic [IW-1:0] WrIndex;
  logic [AW-1:0] WrAdr;
  logic [7:0]    WrCfg;
  logic          Done;
  logic          Err;
  logic [1:0]    ErrCode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmpadrenc #(.PA_BITS(PA), .PMP_ENTRIES(NE)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqBase(ReqBase), .ReqSize(ReqSize),
    .ReqIndex(ReqIndex), .ReqPerm(ReqPerm), .ReqLock(ReqLock),
    .WrValid(WrValid), .WrReady(WrReady), .WrIsCfg(WrIsCfg), .WrIndex(WrIndex),
    .WrAdr(WrAdr), .WrCfg(WrCfg), .Done(Done), .Err(Err), .ErrCode(ErrCode)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [PA-1:0] base, input logic [PA-1:0] size,
                               input int idx, input logic [2:0] perm, input logic lock,
                               input int nwr, input logic err, input logic [1:0] code,
                               input int end_cyc);
    vec_t v;
    v = '0;
    v.base = base; v.size = size; v.idx = IW'(idx); v.perm = perm; v.lock = lock;
    v.nwr = 3'(nwr); v.err = err; v.code = code; v.end_cyc = 5'(end_cyc);
    return v;
  endfunction

  function automatic wr_t wa(input int idx, input logic [AW-1:0] val);
    wa = '{cfg: 1'b0, idx: IW'(idx), val: val};
  endfunction

  function automatic wr_t wc(input int idx, input logic [7:0] cfg);
    wc = '{cfg: 1'b1, idx: IW'(idx), val: AW'(cfg)};
  endfunction

  // Apply one request from edge+1 and watch it to Done/Err; stall = WrReady-low cycles per write
  task automatic run(input vec_t v, input int stall, input string nm);
    wr_t  got [4];
    wr_t  cur, held;
    int   ng = 0;
    int   sc = 0;
    int   endc = -1;
    logic seen_v = 1'b0;
    logic e = 1'b0;
    logic [1:0] ec = 2'b00;
    logic rdy_end = 1'b0;
    held = '0;
    ReqBase = v.base; ReqSize = v.size; ReqIndex = v.idx;
    ReqPerm = v.perm; ReqLock = v.lock; ReqValid = 1'b1;
    WrReady = (stall == 0);
    chk({nm, ".req_ready"}, 64'(ReqReady), 64'(1));
    @(posedge clk); #1;
    ReqValid = 1'b0;
    chk({nm, ".classify_ready"}, 64'(ReqReady), 64'(0));
    for (int c = 1; c < 64; c++) begin
      if (Done || Err) begin
        endc = c; e = Err; ec = ErrCode; rdy_end = ReqReady;
        break;
      end
      if (WrValid) begin
        seen_v = 1'b1;
        cur = '{cfg: WrIsCfg, idx: WrIndex, val: WrIsCfg ? AW'(WrCfg) : WrAdr};
        if (sc == 0) held = cur;
        else chk({nm, ".stable"}, 64'(cur), 64'(held));
        if (sc < stall) begin
          WrReady = 1'b0; sc++;
        end else begin
          WrReady = 1'b1;
          if (ng < 4) got[ng] = cur;
          ng++; sc = 0;
        end
      end else begin
        WrReady = (stall == 0);
      end
      @(posedge clk); #1;
    end
    chk({nm, ".end_cycle"}, 64'(endc), 64'(v.end_cyc));
    chk({nm, ".err"}, 64'(e), 64'(v.err));
    chk({nm, ".ready_at_end"}, 64'(rdy_end), 64'(1));
    if (v.err) chk({nm, ".errcode"}, 64'(ec), 64'(v.code));
    chk({nm, ".any_wrvalid"}, 64'(seen_v), 64'(v.nwr != 0));
    chk({nm, ".nwrites"}, 64'(ng), 64'(v.nwr));
    for (int k = 0; k < 4; k++)
      if (k < int'(v.nwr) && k < ng) chk($sformatf("%s.write%0d", nm, k), 64'(got[k]), 64'(v.w[k]));
    @(posedge clk); #1;
    chk({nm, ".pulse_len"}, 64'({Done, Err}), 64'(0));
    WrReady = 1'b1;
  endtask

  vec_t vecs [12];
  vec_t bp;
  logic found, bad;

  initial begin
    vecs[0] = mkv(56'h8000_0000, 56'h1000, 3, 3'b101, 1'b0, 2, 1'b0, 2'b00, 4);
    vecs[0].w[0] = wa(3, 54'h2000_01FF); vecs[0].w[1] = wc(3, 8'h1D);
    vecs[1] = mkv(56'h1000_0004, 56'h4, 0, 3'b001, 1'b1, 2, 1'b0, 2'b00, 4);
    vecs[1].w[0] = wa(0, 54'h0400_0001); vecs[1].w[1] = wc(0, 8'h91);
    vecs[2] = mkv(56'h8000_0000, 56'h3000, 5, 3'b011, 1'b0, 4, 1'b0, 2'b00, 6);
    vecs[2].w[0] = wa(4, 54'h2000_0000); vecs[2].w[1] = wa(5, 54'h2000_0C00);
    vecs[2].w[2] = wc(4, 8'h00);         vecs[2].w[3] = wc(5, 8'h0B);
    vecs[3] = mkv(56'h1000, 56'h0, 1, 3'b001, 1'b0, 0, 1'b1, 2'b01, 2);
    vecs[4] = mkv(56'h2, 56'h10, 1, 3'b001, 1'b0, 0, 1'b1, 2'b01, 2);
    vecs[5] = mkv(56'hFF_FFFF_FFFF_FFFC, 56'h8, 1, 3'b001, 1'b0, 0, 1'b1, 2'b10, 2);
    vecs[6] = mkv(56'h100, 56'h300, 0, 3'b001, 1'b0, 0, 1'b1, 2'b11, 2);
    vecs[7] = mkv(56'h0, 56'h3000, 0, 3'b111, 1'b1, 2, 1'b0, 2'b00, 4);
    vecs[7].w[0] = wa(0, 54'hC00); vecs[7].w[1] = wc(0, 8'h8F);
    vecs[8] = mkv(56'h1000, 56'h2000, 2, 3'b001, 1'b1, 4, 1'b0, 2'b00, 6);
    vecs[8].w[0] = wa(1, 54'h400); vecs[8].w[1] = wa(2, 54'hC00);
    vecs[8].w[2] = wc(1, 8'h80);   vecs[8].w[3] = wc(2, 8'h89);
    vecs[9] = mkv(56'h1000, 56'h6, 1, 3'b001, 1'b0, 0, 1'b1, 2'b01, 2);
    vecs[10] = mkv(56'hFF_FFFF_FFFF_FFF8, 56'h8, 7, 3'b010, 1'b0, 2, 1'b0, 2'b00, 4);
    vecs[10].w[0] = wa(7, 54'h3F_FFFF_FFFF_FFFE); vecs[10].w[1] = wc(7, 8'h1A);
    vecs[11] = mkv(56'h40, 56'h8, 15, 3'b100, 1'b0, 2, 1'b0, 2'b00, 4);
    vecs[11].w[0] = wa(15, 54'h10); vecs[11].w[1] = wc(15, 8'h1C);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ReqReady", 64'(ReqReady), 64'(1));
    chk("rst.WrValid",  64'(WrValid),  64'(0));
    chk("rst.WrIsCfg",  64'(WrIsCfg),  64'(0));
    chk("rst.WrIndex",  64'(WrIndex),  64'(0));
    chk("rst.WrAdr",    64'(WrAdr),    64'(0));
    chk("rst.WrCfg",    64'(WrCfg),    64'(0));
    chk("rst.Done",     64'(Done),     64'(0));
    chk("rst.Err",      64'(Err),      64'(0));
    chk("rst.ErrCode",  64'(ErrCode),  64'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run(vecs[i], 0, $sformatf("vec%0d", i));

    bp = vecs[2];
    bp.end_cyc = 5'd18;
    run(bp, 3, "tor_backpressure");

    // Reset while the lower-entry cfg write is stalled
    ReqBase = vecs[2].base; ReqSize = vecs[2].size; ReqIndex = vecs[2].idx;
    ReqPerm = vecs[2].perm; ReqLock = vecs[2].lock; ReqValid = 1'b1; WrReady = 1'b1;
    @(posedge clk); #1;
    ReqValid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (WrValid && WrIsCfg && WrIndex == IW'(4)) begin
        found = 1'b1;
        WrReady = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_mid.reached_wcfg0", 64'(found), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.WrValid", 64'(WrValid), 64'(0));
    chk("rst_mid.ReqReady", 64'(ReqReady), 64'(1));
    chk("rst_mid.Done", 64'(Done), 64'(0));
    @(negedge clk) reset = 1'b0;
    WrReady = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (Done || WrValid || !ReqReady) bad = 1'b1;
    end
    chk("rst_mid.quiet_after", 64'(bad), 64'(0));
    run(vecs[0], 0, "after_reset_napot");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
